// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch resolution unit.
// Turns the unsigned comparator flags into a RISC-V conditional-branch
// outcome, computes the next PC, checks it against the front-end prediction
// and holds a multi-cycle flush after a mispredict. Taken and mispredict
// statistics are kept in saturating counters.
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        Funct3,
  input  logic              Predicted,
  input  logic [31:0]       PC,
  input  logic [31:0]       Imm,
  input  logic              ASign,
  input  logic              BSign,
  input  logic              Less,
  input  logic              Equal,
  output logic              OutValid,
  output logic              Taken,
  output logic              Mispredict,
  output logic              Illegal,
  output logic [31:0]       Target,
  output logic              Flush,
  output logic [CNT_W-1:0]  TakenCount,
  output logic [CNT_W-1:0]  MispredCount
);

  // The flush down-counter needs at least one bit even when FLUSH_CYCLES is 1.
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              taken_q, taken_d;
  logic              mispred_q, mispred_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       target_q, target_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  logic              accept;
  logic              less_s;
  logic              br_taken;
  logic              is_illegal;
  logic              res_taken;
  logic              res_mispred;
  logic [31:0]       pc_plus4;
  logic [31:0]       pc_plus_imm;
  logic [31:0]       res_target;

  // Handshake: ready only when idle and not being held in reset.
  assign InReady = (state_q == ST_IDLE) && !Reset;
  assign accept  = InValid && InReady;

  // Decode funct3 into a raw outcome; a sign mismatch decides signed less directly.
  always_comb begin
    less_s     = (ASign != BSign) ? ASign : Less;
    br_taken   = 1'b0;
    is_illegal = 1'b0;
    case (Funct3)
      3'b000:  br_taken = Equal;
      3'b001:  br_taken = !Equal;
      3'b100:  br_taken = less_s;
      3'b101:  br_taken = !less_s;
      3'b110:  br_taken = Less;
      3'b111:  br_taken = !Less;
      default: is_illegal = 1'b1;
    endcase
  end

  // Resolved outcome and next PC; an illegal type is forced not-taken and never mispredicts.
  always_comb begin
    pc_plus4    = PC + 32'd4;
    pc_plus_imm = PC + Imm;
    res_taken   = br_taken && !is_illegal;
    res_mispred = !is_illegal && (res_taken != Predicted);
    res_target  = res_taken ? pc_plus_imm : pc_plus4;
  end

  // Flush FSM: a mispredict holds the unit busy for FLUSH_CYCLES cycles.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && res_mispred) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FC_LOAD;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Result registers: strobe for one cycle, payload held until the next result.
  always_comb begin
    out_valid_d = accept;
    taken_d     = taken_q;
    mispred_d   = mispred_q;
    illegal_d   = illegal_q;
    target_d    = target_q;
    if (accept) begin
      taken_d   = res_taken;
      mispred_d = res_mispred;
      illegal_d = is_illegal;
      target_d  = res_target;
    end
  end

  // Saturating statistics counters, updated alongside the result strobe.
  always_comb begin
    taken_cnt_d   = taken_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (accept && res_taken && (taken_cnt_q != CNT_MAX)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
    if (accept && res_mispred && (mispred_cnt_q != CNT_MAX)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      flush_cnt_q   <= '0;
      out_valid_q   <= 1'b0;
      taken_q       <= 1'b0;
      mispred_q     <= 1'b0;
      illegal_q     <= 1'b0;
      target_q      <= '0;
      taken_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      out_valid_q   <= out_valid_d;
      taken_q       <= taken_d;
      mispred_q     <= mispred_d;
      illegal_q     <= illegal_d;
      target_q      <= target_d;
      taken_cnt_q   <= taken_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign OutValid     = out_valid_q;
  assign Taken        = taken_q;
  assign Mispredict   = mispred_q;
  assign Illegal      = illegal_q;
  assign Target       = target_q;
  assign Flush        = (state_q == ST_FLUSH);
  assign TakenCount   = taken_cnt_q;
  assign MispredCount = mispred_cnt_q;

endmodule
